// File: rtl/u_add_sub_pipe_if.sv
// Operand/result handshake bundle for u_add_sub_pipe; the slave side is the arithmetic unit.
interface u_add_sub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sout;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in1, in2, cin, sub, out_ready,
        input  in_ready, out_valid, sout, cout, ovf, zero
    );

    modport slave (
        input  in_valid, in1, in2, cin, sub, out_ready,
        output in_ready, out_valid, sout, cout, ovf, zero
    );
endinterface

// File: rtl/u_add_sub_pipe.sv
// Segmented-carry add/sub pipeline: one SEG-bit slice resolves per cycle, latency STAGES.
// Backpressure: a single global enable freezes every stage while the output is stalled.
module u_add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst,
    u_add_sub_pipe_if.slave pipe_if
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             en;
    logic [WIDTH-1:0] b_pre;
    logic             c0;

    logic             out_vld_q;
    logic [WIDTH-1:0] sout_q, sout_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             msb_cin;

    assign en               = !out_vld_q || pipe_if.out_ready;
    assign pipe_if.in_ready = en;

    // Subtract is A + ~B + ~borrow, so every stage is a plain adder.
    assign b_pre = pipe_if.sub ? ~pipe_if.in2 : pipe_if.in2;
    assign c0    = pipe_if.sub ? ~pipe_if.cin : pipe_if.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        logic                vld_in;
        logic                c_in;
        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic [SEG-1:0]      s_seg;
        logic                c_out;
        logic [HI-1:0]       res;

        assign {c_out, s_seg} = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                              + {{SEG{1'b0}}, c_in};

        if (k == 0) begin : g_head
            assign vld_in = pipe_if.in_valid;
            assign a_in   = pipe_if.in1;
            assign b_in   = b_pre;
            assign c_in   = c0;
            assign res    = s_seg;
        end else begin : g_body
            logic                vld_q;
            logic                c_q;
            logic [LO-1:0]       lo_q;
            logic [WIDTH-LO-1:0] a_q;
            logic [WIDTH-LO-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (en) begin
                    vld_q <= g_stg[k-1].vld_in;
                end
            end

            // Upper operand slices ride along so they meet this stage's carry.
            always_ff @(posedge clk) begin
                if (en) begin
                    c_q  <= g_stg[k-1].c_out;
                    lo_q <= g_stg[k-1].res;
                    a_q  <= g_stg[k-1].a_in[WIDTH-LO+SEG-1:SEG];
                    b_q  <= g_stg[k-1].b_in[WIDTH-LO+SEG-1:SEG];
                end
            end

            assign vld_in = vld_q;
            assign a_in   = a_q;
            assign b_in   = b_q;
            assign c_in   = c_q;
            assign res    = {s_seg, lo_q};
        end
    end

    assign msb_cin = g_stg[LAST].a_in[SEG-1] ^ g_stg[LAST].b_in[SEG-1]
                   ^ g_stg[LAST].s_seg[SEG-1];

    always_comb begin
        sout_d = g_stg[LAST].res;
        cout_d = g_stg[LAST].c_out;
        ovf_d  = msb_cin ^ g_stg[LAST].c_out;
        zero_d = (g_stg[LAST].res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            sout_q    <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (en) begin
            out_vld_q <= g_stg[LAST].vld_in;
            if (g_stg[LAST].vld_in) begin
                sout_q <= sout_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign pipe_if.out_valid = out_vld_q;
    assign pipe_if.sout      = sout_q;
    assign pipe_if.cout      = cout_q;
    assign pipe_if.ovf       = ovf_q;
    assign pipe_if.zero      = zero_q;
endmodule

// File: tb/tb_u_add_sub_pipe.sv
// Directed bench for u_add_sub_pipe (WIDTH=32, STAGES=4) with an in-order result scoreboard.
module tb_u_add_sub_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    res_t q[$];

    u_add_sub_pipe_if #(.WIDTH(32)) bus();

    u_add_sub_pipe #(.WIDTH(32), .STAGES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .pipe_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        res_t        r;
        logic [31:0] bb;
        logic        cc;
        logic [32:0] t;
        bb  = sb ? ~b : b;
        cc  = sb ? ~ci : ci;
        t   = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
        r.s = t[31:0];
        r.c = t[32];
        r.o = (a[31] == bb[31]) && (t[31] != a[31]);
        r.z = (t[31:0] == 32'd0);
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
        bus.in1 = a;
        bus.in2 = b;
        bus.cin = ci;
        bus.sub = sb;
    endtask

    // One clock: score the beat leaving, record the beat entering, advance.
    task automatic tick(output bit acc);
        res_t r;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_pending", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                r = q.pop_front();
                chk("sb_sout", bus.sout, r.s);
                chk("sb_cout", bus.cout, r.c);
                chk("sb_ovf",  bus.ovf,  r.o);
                chk("sb_zero", bus.zero, r.z);
            end
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) q.push_back(model(bus.in1, bus.in2, bus.cin, bus.sub));
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
        bit acc;
        drive(a, b, ci, sb);
        bus.in_valid = 1'b1;
        tick(acc);
        chk({tag, "_acc"}, acc, 1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_early_vld"}, bus.out_valid, 0);
            tick(acc);
        end
        chk({tag, "_vld"},  bus.out_valid, 1);
        chk({tag, "_sout"}, bus.sout, es);
        chk({tag, "_cout"}, bus.cout, ec);
        chk({tag, "_ovf"},  bus.ovf,  eo);
        chk({tag, "_zero"}, bus.zero, ez);
    endtask

    initial begin
        bit          acc;
        bit          stall;
        int          idx;
        logic        exp_vld;
        logic [31:0] ra [10];
        logic [31:0] rb [10];
        logic        rc [10];
        logic        rs [10];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vld",  bus.out_valid, 0);
        chk("reset_sout", bus.sout, 0);
        chk("reset_cout", bus.cout, 0);
        chk("reset_ovf",  bus.ovf,  0);
        chk("reset_zero", bus.zero, 0);

        rst           = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", bus.in_ready, 1);
        bus.out_ready = 1'b1;

        single("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single("seg8",     32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        single("seg24",    32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        single("ovf_add",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        single("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        single("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        single("add_cin",  32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0, 1'b0);
        single("sub_bin",  32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
        single("sub_zero", 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Back-to-back stream with a 3-cycle output stall in the middle.
        for (int i = 0; i < 10; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rc[i] = 1'($urandom_range(0, 1));
            rs[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int cyc = 0; cyc < 13; cyc++) begin
            stall         = (cyc >= 5) && (cyc <= 7);
            bus.out_ready = !stall;
            bus.in_valid  = (idx < 10);
            if (idx < 10) drive(ra[idx], rb[idx], rc[idx], rs[idx]);
            #1;
            chk("bp_in_ready", bus.in_ready, !stall);
            if (stall) begin
                chk("bp_hold_vld", bus.out_valid, 1);
                if (q.size() != 0) begin
                    chk("bp_hold_sout", bus.sout, q[0].s);
                    chk("bp_hold_cout", bus.cout, q[0].c);
                end
            end
            tick(acc);
            if (acc) idx++;
        end
        chk("bp_all_accepted", idx, 10);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) tick(acc);
        chk("bp_drained", q.size(), 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            drive(32'(i * 3 + 1), 32'(i + 10), 1'b0, 1'b0);
            bus.in_valid = 1'b1;
            tick(acc);
            chk("rst_acc", acc, 1);
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick(acc);
        q.delete();
        chk("rst_vld",  bus.out_valid, 0);
        chk("rst_sout", bus.sout, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf",  bus.ovf,  0);
        chk("rst_zero", bus.zero, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(acc);
            chk("rst_flush_vld", bus.out_valid, 0);
        end
        single("rst_new", 32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);

        // Alternating beats and bubbles.
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = (c < 8) && (c % 2 == 0);
            drive(32'h100 * 32'(c), 32'(c), 1'b1, 1'b0);
            tick(acc);
            exp_vld = (c >= 3) && (c <= 10) && ((c - 3) % 2 == 0);
            chk("bubble_vld", bus.out_valid, exp_vld);
        end
        bus.in_valid = 1'b0;
        repeat (6) tick(acc);
        chk("final_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/u_add_sub_pipe.md
# u_add_sub_pipe

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake. The WIDTH-bit carry chain is split into STAGES equal segments, and one segment resolves per clock. This gives a result every cycle at a fixed latency of STAGES. It replaces the flat 32-bit ripple adder in datapaths that need a registered, back-pressurable arithmetic unit. It also adds subtract mode, signed-overflow and zero flags.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage resolves SEG = WIDTH/STAGES bits; 1 ≤ STAGES ≤ WIDTH.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sout  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB; in sub mode, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sout == 0.

## Operation
- Operand preprocessing at input:
  - b = sub ? ~in2 : in2.
  - c0 = sub ? ~cin : cin.
  - The result is A + b + c0 in both modes.
- Stage k (0..STAGES−1):
  - Adds segment k of A and b plus the carry registered from stage k−1 (c0 for stage 0).
  - Registers the SEG sum bits and the segment carry.
- Alignment registers:
  - Unconsumed upper operand segments are delayed alongside the data so they reach stage k exactly when its carry arrives.
  - Lower result segments are delayed to the last stage, so every result bit of a beat leaves together.
- Per-stage valid bit travels with the data.
- Global advance enable: en = !out_valid || out_ready; in_ready = en.
  - When en = 0, every pipeline register and valid bit holds.
  - Bubbles are not squeezed out.
- A beat is accepted when in_valid && in_ready. If in_valid = 0 while en = 1, a bubble (valid = 0) enters stage 0.
- Flags, computed in the last stage from the final beat:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sout == 0).
- Output hold: sout, cout, ovf and zero are stable while out_valid && !out_ready.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated.

## Timing
- Reset: on a clk edge with rst = 1, the following clear to 0:
  - all valid bits, so out_valid = 0;
  - sout, cout, ovf and zero.
  - in_ready during reset is don't-care; in_ready = 1 on the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded, and no result from before reset ever appears at the output. rst has priority over en.
- Latency: a beat accepted at edge n presents out_valid = 1 after edge n+STAGES−1, i.e. with STAGES register levels and zero stall cycles.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: each cycle with out_valid && !out_ready adds exactly one cycle of latency to every in-flight beat.
- in_ready is combinational from out_ready and out_valid only; it has no path from in_valid.
- STAGES = 1: a single registered adder with the same handshake and latency 1.
- Width wrap: sums ≥ 2^WIDTH wrap modulo 2^WIDTH and set cout = 1.

## Test plan
Configuration for all scenarios: WIDTH=32, STAGES=4, out_ready=1 unless noted.
- Wrap: 0xFFFFFFFF + 0x00000001, cin=0, sub=0 → 4 cycles later: sout=0x00000000, cout=1, zero=1, ovf=0.
- Segment-boundary carry:
  - 0x000000FF + 0x00000001 → sout=0x00000100, cout=0.
  - 0x00FFFFFF + 0x00000001, cin=0 → sout=0x01000000 (carry crosses all stages).
- Overflow and subtract:
  - 0x7FFFFFFF + 0x00000001 → sout=0x80000000, ovf=1, cout=0.
  - sub=1: 5 − 7 − 0 → sout=0xFFFFFFFE, cout=0, ovf=0.
  - sub=1: 0x80000000 − 1 → sout=0x7FFFFFFF, ovf=1.
- Backpressure:
  - Stimulus: stream 10 random beats back-to-back; hold out_ready=0 for 3 cycles mid-stream.
  - Required response: in_ready=0 exactly during those cycles; outputs held stable; all 10 results correct and in order, checked against A + (sub ? −B−cin : B+cin) mod 2^32.
- Reset mid-flight:
  - Stimulus: accept 3 beats, assert rst for 1 cycle.
  - Required response: out_valid=0 and all outputs 0 next cycle; none of the 3 results ever appear; a new beat 2+3 yields sout=5 after 4 cycles.
- Bubbles: alternate in_valid 1/0 → out_valid alternates 1/0 with matching results, 4-cycle latency.
